// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router datapath.
// Header layout: addr in [1:0], payload length in [7:2].
package router_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = 1;
  localparam int LEN_LSB  = 2;
  localparam int LEN_MSB  = 7;
  localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;

endpackage

// File: rtl/router_parity_chk.sv
// Running packet parity, captured parity byte and the mismatch flag.
// err holds until the next packet begins loading.
module router_parity_chk
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  full_state,
  input  logic                  rst_int_reg,
  input  logic                  pkt_valid,
  input  logic                  low_pkt_valid,
  input  logic                  parity_done,
  input  logic [DATA_WIDTH-1:0] hdr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  err
);

  logic [DATA_WIDTH-1:0] int_parity;
  logic [DATA_WIDTH-1:0] pkt_parity;

  // Bytes stalled into the hold register are still folded in here once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      int_parity <= '0;
    end else if (detect_add) begin
      int_parity <= '0;
    end else if (lfd_state) begin
      int_parity <= int_parity ^ hdr;
    end else if (ld_state && pkt_valid && !full_state) begin
      int_parity <= int_parity ^ data_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pkt_parity <= '0;
    end else if (detect_add) begin
      pkt_parity <= '0;
    end else if (ld_state && !pkt_valid && !low_pkt_valid) begin
      pkt_parity <= data_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (rst_int_reg && parity_done) begin
      err <= (int_parity != pkt_parity);
    end else if (lfd_state) begin
      err <= 1'b0;
    end
  end

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage feeding the output FIFOs.
// Optional length check enabled by ROUTER_REG_LEN_CHECK_EN.
module router_reg
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  rst_int_reg,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  parity_done,
  output logic                  low_pkt_valid,
  output logic                  err
`ifdef ROUTER_REG_LEN_CHECK_EN
  ,
  output logic                  len_err
`endif
);

  logic [DATA_WIDTH-1:0] hdr;
  logic [DATA_WIDTH-1:0] full_hold;
  logic                  hdr_ok;

  assign hdr_ok = data_in[ADDR_MSB:ADDR_LSB] != ADDR_INVALID;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hdr <= '0;
    end else if (detect_add && pkt_valid && hdr_ok) begin
      hdr <= data_in;
    end
  end

  // A byte arriving while the FIFO is full is parked until laf_state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout      <= '0;
      full_hold <= '0;
    end else if (lfd_state) begin
      dout <= hdr;
    end else if (ld_state && !fifo_full) begin
      dout <= data_in;
    end else if (ld_state) begin
      full_hold <= data_in;
    end else if (laf_state) begin
      dout <= full_hold;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      low_pkt_valid <= 1'b0;
    end else if (rst_int_reg || detect_add) begin
      low_pkt_valid <= 1'b0;
    end else if (ld_state && !pkt_valid) begin
      low_pkt_valid <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parity_done <= 1'b0;
    end else if ((ld_state && !fifo_full && !pkt_valid) ||
                 (laf_state && low_pkt_valid && !parity_done)) begin
      parity_done <= 1'b1;
    end else if (detect_add) begin
      parity_done <= 1'b0;
    end
  end

  router_parity_chk #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .clock         (clock),
    .reset         (reset),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .pkt_valid     (pkt_valid),
    .low_pkt_valid (low_pkt_valid),
    .parity_done   (parity_done),
    .hdr           (hdr),
    .data_in       (data_in),
    .err           (err)
  );

`ifdef ROUTER_REG_LEN_CHECK_EN
  logic [LEN_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (detect_add) begin
      count <= '0;
    end else if (ld_state && pkt_valid && !full_state && count != '1) begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_err <= 1'b0;
    end else if (rst_int_reg) begin
      len_err <= (count != hdr[LEN_MSB:LEN_LSB]);
    end else if (lfd_state) begin
      len_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_router_reg.sv
// Self-checking bench for router_reg: directed and random packets
// driven through a hand-sequenced FSM strobe pattern.
module tb_router_reg;

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add, lfd_state, ld_state;
  logic       laf_state, full_state, rst_int_reg;
  logic [7:0] dout;
  logic       parity_done, low_pkt_valid, err;
`ifdef ROUTER_REG_LEN_CHECK_EN
  logic       len_err;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] last_dout = 8'h00;
  logic [7:0] last_hdr  = 8'h00;

  always #5 clock = ~clock;

  router_reg dut (
    .clock         (clock),
    .reset         (reset),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .dout          (dout),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .err           (err)
`ifdef ROUTER_REG_LEN_CHECK_EN
    ,
    .len_err       (len_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    detect_add  = 0; lfd_state  = 0; ld_state    = 0;
    laf_state   = 0; full_state = 0; rst_int_reg = 0;
    fifo_full   = 0;
  endtask

  // stall: payload index stalled by fifo_full, pay.size() = parity byte, -1 none
  task automatic send_pkt(input logic [7:0] h, input logic [7:0] pay[$],
                          input bit bad, input int stall);
    logic [7:0] par;
    logic [7:0] pb;
    logic [7:0] prev;
    int n;
    n = pay.size();
    par = h;
    foreach (pay[i]) par ^= pay[i];
    pb = bad ? (par ^ 8'h01) : par;

    idle();
    detect_add = 1; pkt_valid = 1; data_in = h;
    tick();
    detect_add = 0;
    chk("pdone_clr", parity_done, 0);
    chk("lowpv_clr", low_pkt_valid, 0);

    lfd_state = 1;
    data_in = (n > 0) ? pay[0] : 8'h00;
    tick();
    lfd_state = 0;
    chk("dout_hdr", dout, h);
    chk("err_lfd", err, 0);
    prev = h;

    for (int i = 0; i < n; i++) begin
      ld_state = 1; pkt_valid = 1; data_in = pay[i];
      fifo_full = (i == stall);
      tick();
      if (i == stall) begin
        chk("dout_stall", dout, prev);
        ld_state = 0; fifo_full = 0; full_state = 1;
        tick();
        full_state = 0; laf_state = 1;
        tick();
        laf_state = 0;
        chk("dout_laf", dout, pay[i]);
        chk("pdone_mid", parity_done, 0);
      end else begin
        chk("dout_pay", dout, pay[i]);
      end
      prev = pay[i];
    end

    ld_state = 1; pkt_valid = 0; data_in = pb;
    fifo_full = (stall == n);
    tick();
    ld_state = 0; fifo_full = 0;
    chk("lowpv_set", low_pkt_valid, 1);
    if (stall == n) begin
      chk("pdone_wait", parity_done, 0);
      chk("dout_phold", dout, prev);
      full_state = 1;
      tick();
      full_state = 0; laf_state = 1;
      tick();
      laf_state = 0;
    end
    chk("dout_par", dout, pb);
    chk("pdone_set", parity_done, 1);

    rst_int_reg = 1;
    tick();
    rst_int_reg = 0;
    chk("err_eval", err, bad);
    chk("lowpv_rst", low_pkt_valid, 0);
`ifdef ROUTER_REG_LEN_CHECK_EN
    chk("len_err", len_err, (n != int'(h[7:2])));
`endif
    tick();
    chk("err_hold", err, bad);
    last_dout = pb;
    last_hdr  = h;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] h;
    int n;

    idle();
    pkt_valid = 0;
    data_in = 8'h00;
    reset = 1;
    #12;
    chk("rst_dout", dout, 0);
    chk("rst_pdone", parity_done, 0);
    chk("rst_lowpv", low_pkt_valid, 0);
    chk("rst_err", err, 0);
    @(negedge clock);
    reset = 0;

    q = '{8'h11, 8'h22, 8'h33};
    send_pkt(8'h0C, q, 0, -1);
    send_pkt(8'h0C, q, 1, -1);
    send_pkt(8'h0C, q, 0, 1);
    send_pkt(8'h0C, q, 0, 3);
    send_pkt(8'h11, q, 0, -1);

    // invalid address: header register must keep the last good header
    idle();
    detect_add = 1; pkt_valid = 1; data_in = 8'h13;
    tick();
    detect_add = 0;
    chk("inv_dout", dout, last_dout);
    lfd_state = 1;
    tick();
    lfd_state = 0;
    chk("inv_hdr", dout, last_hdr);

    // reset mid-payload with no clock edge
    q = '{8'hAA, 8'hBB};
    detect_add = 1; pkt_valid = 1; data_in = 8'h09;
    tick();
    detect_add = 0; lfd_state = 1; data_in = 8'hAA;
    tick();
    lfd_state = 0; ld_state = 1;
    tick();
    ld_state = 0;
    chk("pre_rst", dout, 8'hAA);
    #2;
    reset = 1;
    #1;
    chk("arst_dout", dout, 0);
    chk("arst_pdone", parity_done, 0);
    chk("arst_lowpv", low_pkt_valid, 0);
    chk("arst_err", err, 0);
    @(negedge clock);
    reset = 0;
    send_pkt(8'h09, q, 0, -1);

    repeat (25) begin
      n = $urandom_range(1, 6);
      h = {6'(n), 2'($urandom_range(0, 2))};
      q.delete();
      repeat (n) q.push_back(8'($urandom_range(0, 255)));
      send_pkt(h, q, bit'($urandom_range(0, 1)),
               int'($urandom_range(0, n + 2)) - 1);
    end

    idle();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
